// File: rtl/scroll_offset_ctrl.sv
// scroll_offset_ctrl
//   Frame-rate animation controller in the pixel clock domain. Detects each frame
//   start from the rising edge of vsync, advances a horizontal scroll offset
//   modulo PERIOD by a switch-selected step, and gates player visibility behind a
//   short warm-up (WAIT -> RUN) state machine.
//
// Ports
//   clk          pixel clock
//   reset        synchronous, active-high reset
//   vsync_in     vsync from the sync generator, active high
//   speed_in     scroll step in pixels per frame (0 behaves as 1)
//   dir_in       0 = offset increases, 1 = offset decreases
//   pause_in     1 = hold x_offset on frame ticks while running
//   x_offset     registered scroll offset, always 0..PERIOD-1
//   frame_tick   registered one-cycle pulse per frame start
//   running      high in RUN; player show enable
//   frame_count  RUN-state frame counter, wraps 255 -> 0
module scroll_offset_ctrl #(
  parameter int unsigned PERIOD       = 400,
  parameter int unsigned OFS_W        = 10,
  parameter int unsigned START_FRAMES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             vsync_in,
  input  logic [3:0]       speed_in,
  input  logic             dir_in,
  input  logic             pause_in,
  output logic [OFS_W-1:0] x_offset,
  output logic             frame_tick,
  output logic             running,
  output logic [7:0]       frame_count
);

  localparam int unsigned WarmW = (START_FRAMES > 1) ? $clog2(START_FRAMES) : 1;
  localparam logic [OFS_W:0]   PeriodExt = (OFS_W + 1)'(PERIOD);
  localparam logic [WarmW-1:0] WarmLast  = WarmW'(START_FRAMES - 1);

  typedef enum logic [0:0] {StWait, StRun} state_e;

  state_e           state_q;
  logic             vsync_q;
  logic [WarmW-1:0] warm_cnt_q;
  logic [OFS_W-1:0] x_offset_q;
  logic             frame_tick_q;
  logic             running_q;
  logic [7:0]       frame_count_q;

  logic             tick;
  logic [OFS_W:0]   step;
  logic [OFS_W:0]   ofs_ext;
  logic [OFS_W:0]   fwd_sum;
  logic [OFS_W:0]   next_ext;
  logic [OFS_W-1:0] x_offset_d;

  assign tick = vsync_in & ~vsync_q;

  // One extra bit of headroom so x_offset + step and x_offset + PERIOD cannot overflow
  // before the single conditional subtract brings them back into range.
  always_comb begin
    step     = (speed_in == 4'd0) ? (OFS_W + 1)'(1) : (OFS_W + 1)'(speed_in);
    ofs_ext  = {1'b0, x_offset_q};
    fwd_sum  = ofs_ext + step;
    next_ext = ofs_ext;
    if (!dir_in) begin
      next_ext = (fwd_sum >= PeriodExt) ? fwd_sum - PeriodExt : fwd_sum;
    end else begin
      next_ext = (ofs_ext >= step) ? ofs_ext - step : ofs_ext + PeriodExt - step;
    end
    x_offset_d = next_ext[OFS_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StWait;
      vsync_q       <= 1'b0;
      warm_cnt_q    <= '0;
      x_offset_q    <= '0;
      frame_tick_q  <= 1'b0;
      running_q     <= 1'b0;
      frame_count_q <= 8'd0;
    end else begin
      vsync_q      <= vsync_in;
      frame_tick_q <= tick;
      if (tick) begin
        unique case (state_q)
          StWait: begin
            warm_cnt_q <= warm_cnt_q + 1'b1;
            if (warm_cnt_q == WarmLast) begin
              state_q   <= StRun;
              running_q <= 1'b1;
            end
          end
          StRun: begin
            frame_count_q <= frame_count_q + 8'd1;
            if (!pause_in) begin
              x_offset_q <= x_offset_d;
            end
          end
          default: state_q <= StWait;
        endcase
      end
    end
  end

  assign x_offset    = x_offset_q;
  assign frame_tick  = frame_tick_q;
  assign running     = running_q;
  assign frame_count = frame_count_q;

endmodule
